// File: rtl/tim_pkg.sv
// Shared definitions for the timer time-base slice.
//   CNT_W_DEFAULT : default width of counter, prescaler and auto-reload values
//   sms_e         : slave-mode select encodings seen on sms_i
package tim_pkg;

    localparam int CNT_W_DEFAULT = 16;

    typedef enum logic [2:0] {
        SMS_INTERNAL = 3'b000,
        SMS_ENC1     = 3'b001,
        SMS_ENC2     = 3'b010,
        SMS_RESET    = 3'b100,
        SMS_GATED    = 3'b101,
        SMS_TRIGGER  = 3'b110,
        SMS_EXTERNAL = 3'b111
    } sms_e;

endpackage

// File: rtl/tb_prescaler.sv
// Time-base prescaler: divides qualified steps by (shadow + 1).
// Ports:
//   clk_i      : clock, rising edge
//   rst_i      : synchronous active-high reset
//   step_i     : qualified step (counter enable AND slave-mode step)
//   update_i   : update event; restarts the divider and loads the shadow
//   psc_i      : prescaler value captured into the shadow on update
//   ck_cnt_o   : one-cycle counter clock-enable, asserted on divider wrap
module tb_prescaler #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         step_i,
    input  logic         update_i,
    input  logic [W-1:0] psc_i,
    output logic         ck_cnt_o
);

    logic [W-1:0] psc_cnt_q, psc_cnt_d;
    logic [W-1:0] psc_shadow_q, psc_shadow_d;

    // The wrap cycle is the cycle the divider emits its pulse, so a zero
    // shadow yields a pulse on every qualified step.
    assign ck_cnt_o = step_i && (psc_cnt_q == psc_shadow_q);

    always_comb begin
        psc_cnt_d    = psc_cnt_q;
        psc_shadow_d = psc_shadow_q;
        if (update_i) begin
            psc_cnt_d    = '0;
            psc_shadow_d = psc_i;
        end else if (step_i) begin
            psc_cnt_d = ck_cnt_o ? '0 : psc_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            psc_cnt_q    <= '0;
            psc_shadow_q <= '0;
        end else begin
            psc_cnt_q    <= psc_cnt_d;
            psc_shadow_q <= psc_shadow_d;
        end
    end

endmodule

// File: rtl/time_base_unit.sv
// Timer time-base unit: prescaled up/down counter with auto-reload,
// one-pulse mode, gated slave mode and update-event generation.
// Ports:
//   clk_i, rst_i                 : clock and synchronous active-high reset
//   step_i                       : prescaler step qualifier
//   sms_i                        : slave mode select (3'b101 gated)
//   sm_reset_i/sm_gate_i/sm_trig_i : slave-mode levels
//   cen_i, dir_i, opm_i, arpe_i, udis_i, urs_i, ug_i : control bits
//   psc_i, arr_i                 : prescaler and auto-reload values
//   uif_clr_i                    : update flag clear pulse
//   cnt_o, uev_o, uif_o, cnt_en_o : counter, update pulse, flag, enable
module time_base_unit
    import tim_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             step_i,
    input  logic [2:0]       sms_i,
    input  logic             sm_reset_i,
    input  logic             sm_gate_i,
    input  logic             sm_trig_i,
    input  logic             cen_i,
    input  logic             dir_i,
    input  logic             opm_i,
    input  logic             arpe_i,
    input  logic             udis_i,
    input  logic             urs_i,
    input  logic             ug_i,
    input  logic [CNT_W-1:0] psc_i,
    input  logic [CNT_W-1:0] arr_i,
    input  logic             uif_clr_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             uev_o,
    output logic             uif_o,
    output logic             cnt_en_o
);

    logic             cen_q, trig_q, smrst_q;
    logic             run_q, run_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] arr_shadow_q, arr_shadow_d;
    logic             uev_q, uev_d;
    logic             uif_q, uif_d;

    logic             cen_rise, cen_fall, trig_rise, smrst_rise;
    logic             sw_update, ck_cnt, ovf, unf, wrap, uif_set;
    logic [CNT_W-1:0] arr_active;

    // Gated mode masks the run flag with the gate level; all other modes
    // count whenever the run flag is set.
    assign cnt_en_o = run_q && ((sms_i == SMS_GATED) ? sm_gate_i : 1'b1);

    tb_prescaler #(.W(CNT_W)) u_prescaler (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .step_i   (cnt_en_o && step_i),
        .update_i (uev_d),
        .psc_i    (psc_i),
        .ck_cnt_o (ck_cnt)
    );

    // Edge detection, event decoding and next-state selection. A software
    // or slave-mode reset pre-empts any count in the same cycle, so wraps
    // are only recognised when no such reset is present.
    always_comb begin
        cen_rise   = cen_i && !cen_q;
        cen_fall   = !cen_i && cen_q;
        trig_rise  = sm_trig_i && !trig_q;
        smrst_rise = sm_reset_i && !smrst_q;
        sw_update  = ug_i || smrst_rise;
        arr_active = arpe_i ? arr_shadow_q : arr_i;

        ovf  = ck_cnt && !sw_update && !dir_i && (cnt_q == arr_active);
        unf  = ck_cnt && !sw_update && dir_i && (cnt_q == '0);
        wrap = ovf || unf;

        uev_d   = sw_update || (wrap && !udis_i);
        uif_set = (wrap && !udis_i) || (sw_update && !urs_i);

        cnt_d = cnt_q;
        if (sw_update) begin
            cnt_d = dir_i ? arr_active : '0;
        end else if (ck_cnt) begin
            if (dir_i) begin
                cnt_d = (cnt_q == '0) ? arr_active : cnt_q - 1'b1;
            end else begin
                cnt_d = (cnt_q == arr_active) ? '0 : cnt_q + 1'b1;
            end
        end

        arr_shadow_d = uev_d ? arr_i : arr_shadow_q;

        run_d = run_q;
        if (cen_fall || (opm_i && wrap)) begin
            run_d = 1'b0;
        end
        if (cen_rise || trig_rise) begin
            run_d = 1'b1;
        end

        uif_d = uif_q;
        if (uif_clr_i) begin
            uif_d = 1'b0;
        end
        if (uif_set) begin
            uif_d = 1'b1;
        end
    end

    // State registers; reset overrides every event and never raises uev.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cen_q        <= 1'b0;
            trig_q       <= 1'b0;
            smrst_q      <= 1'b0;
            run_q        <= 1'b0;
            cnt_q        <= '0;
            arr_shadow_q <= '1;
            uev_q        <= 1'b0;
            uif_q        <= 1'b0;
        end else begin
            cen_q        <= cen_i;
            trig_q       <= sm_trig_i;
            smrst_q      <= sm_reset_i;
            run_q        <= run_d;
            cnt_q        <= cnt_d;
            arr_shadow_q <= arr_shadow_d;
            uev_q        <= uev_d;
            uif_q        <= uif_d;
        end
    end

    assign cnt_o = cnt_q;
    assign uev_o = uev_q;
    assign uif_o = uif_q;

endmodule

// File: tb/tb_time_base_unit.sv
// Directed self-checking bench for time_base_unit.
module tb_time_base_unit;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst, step, sm_reset, sm_gate, sm_trig;
    logic [2:0]   sms;
    logic         cen, dir, opm, arpe, udis, urs, ug, uif_clr;
    logic [W-1:0] psc, arr;
    logic [W-1:0] cnt;
    logic         uev, uif, cnt_en;

    int total  = 0;
    int passed = 0;

    time_base_unit #(.CNT_W(W)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .step_i     (step),
        .sms_i      (sms),
        .sm_reset_i (sm_reset),
        .sm_gate_i  (sm_gate),
        .sm_trig_i  (sm_trig),
        .cen_i      (cen),
        .dir_i      (dir),
        .opm_i      (opm),
        .arpe_i     (arpe),
        .udis_i     (udis),
        .urs_i      (urs),
        .ug_i       (ug),
        .psc_i      (psc),
        .arr_i      (arr),
        .uif_clr_i  (uif_clr),
        .cnt_o      (cnt),
        .uev_o      (uev),
        .uif_o      (uif),
        .cnt_en_o   (cnt_en)
    );

    always #5 clk = ~clk;

    // One clock: outputs are sampled and inputs changed 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Quiet all controls and apply a one-cycle reset.
    task automatic applyStimulus();
        step = 1'b1; sms = 3'b000; sm_reset = 1'b0; sm_gate = 1'b0; sm_trig = 1'b0;
        cen = 1'b0; dir = 1'b0; opm = 1'b0; arpe = 1'b0; udis = 1'b0; urs = 1'b0;
        ug = 1'b0; uif_clr = 1'b0; psc = '0; arr = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        applyStimulus();
        total++; if (cnt !== 16'd0) $display("[TB] FAIL reset_cnt got %0d want 0", cnt); else passed++;
        total++; if ({uev, uif, cnt_en} !== 3'b000)
            $display("[TB] FAIL reset_flags got %b want 000", {uev, uif, cnt_en}); else passed++;
    endtask

    task automatic test_up_count();
        logic [W-1:0] expCnt [4] = '{16'd1, 16'd2, 16'd3, 16'd0};
        applyStimulus();
        arr = 16'd3; cen = 1'b1;
        tick();
        total++; if (cnt_en !== 1'b1) $display("[TB] FAIL up_enable got %b want 1", cnt_en); else passed++;
        for (int k = 0; k < 4; k++) begin
            tick();
            total++; if (cnt !== expCnt[k]) $display("[TB] FAIL up_cnt[%0d] got %0d want %0d", k, cnt, expCnt[k]); else passed++;
            total++; if ({uev, uif} !== {2{k == 3}})
                $display("[TB] FAIL up_flags[%0d] got %b want %b", k, {uev, uif}, {2{k == 3}}); else passed++;
        end
        tick();
        total++; if ({cnt, uev, uif} !== {16'd1, 1'b0, 1'b1})
            $display("[TB] FAIL up_after got cnt=%0d uev=%b uif=%b want 1 0 1", cnt, uev, uif); else passed++;
        uif_clr = 1'b1;
        tick();
        uif_clr = 1'b0;
        total++; if (uif !== 1'b0) $display("[TB] FAIL up_uifclr got %b want 0", uif); else passed++;
    endtask

    task automatic test_down_prescale();
        logic [W-1:0] exp;
        applyStimulus();
        psc = 16'd2; arr = 16'd5; dir = 1'b1; ug = 1'b1;
        tick();
        ug = 1'b0;
        total++; if ({cnt, uev, uif} !== {16'd5, 1'b1, 1'b1})
            $display("[TB] FAIL down_ug got cnt=%0d uev=%b uif=%b want 5 1 1", cnt, uev, uif); else passed++;
        uif_clr = 1'b1; cen = 1'b1;
        tick();
        uif_clr = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            tick();
            exp = (k == 18) ? 16'd5 : 16'(5 - k / 3);
            total++; if (cnt !== exp) $display("[TB] FAIL down_cnt[%0d] got %0d want %0d", k, cnt, exp); else passed++;
            total++; if (uev !== (k == 18)) $display("[TB] FAIL down_uev[%0d] got %b want %b", k, uev, k == 18); else passed++;
        end
    endtask

    task automatic test_arpe();
        applyStimulus();
        arpe = 1'b1; arr = 16'd3; ug = 1'b1;
        tick();
        ug = 1'b0; cen = 1'b1;
        tick();
        tick();
        tick();
        total++; if (cnt !== 16'd2) $display("[TB] FAIL arpe_pre got %0d want 2", cnt); else passed++;
        arr = 16'd7;
        tick();
        total++; if (cnt !== 16'd3) $display("[TB] FAIL arpe_3 got %0d want 3", cnt); else passed++;
        tick();
        total++; if ({cnt, uev} !== {16'd0, 1'b1})
            $display("[TB] FAIL arpe_wrap got cnt=%0d uev=%b want 0 1", cnt, uev); else passed++;
        for (int k = 1; k <= 8; k++) begin
            tick();
            total++; if ({cnt, uev} !== {16'(k % 8), k == 8})
                $display("[TB] FAIL arpe_p8[%0d] got cnt=%0d uev=%b want %0d %b", k, cnt, uev, k % 8, k == 8); else passed++;
        end
    endtask

    task automatic test_one_pulse();
        applyStimulus();
        opm = 1'b1; arr = 16'd2; cen = 1'b1;
        tick();
        tick();
        tick();
        tick();
        total++; if ({cnt, uev, cnt_en} !== {16'd0, 1'b1, 1'b0})
            $display("[TB] FAIL opm_stop got cnt=%0d uev=%b en=%b want 0 1 0", cnt, uev, cnt_en); else passed++;
        tick();
        tick();
        total++; if ({cnt, cnt_en} !== {16'd0, 1'b0})
            $display("[TB] FAIL opm_hold got cnt=%0d en=%b want 0 0", cnt, cnt_en); else passed++;
        sm_trig = 1'b1;
        tick();
        total++; if ({cnt, cnt_en} !== {16'd0, 1'b1})
            $display("[TB] FAIL opm_trig got cnt=%0d en=%b want 0 1", cnt, cnt_en); else passed++;
        tick();
        sm_trig = 1'b0;
        total++; if (cnt !== 16'd1) $display("[TB] FAIL opm_restart got %0d want 1", cnt); else passed++;
    endtask

    task automatic test_gated_smreset();
        applyStimulus();
        sms = 3'b101; sm_gate = 1'b1; arr = 16'd9; cen = 1'b1;
        tick();
        tick();
        tick();
        total++; if (cnt !== 16'd2) $display("[TB] FAIL gate_run got %0d want 2", cnt); else passed++;
        sm_gate = 1'b0;
        #1;
        total++; if (cnt_en !== 1'b0) $display("[TB] FAIL gate_en got %b want 0", cnt_en); else passed++;
        tick();
        tick();
        total++; if (cnt !== 16'd2) $display("[TB] FAIL gate_hold got %0d want 2", cnt); else passed++;
        sm_gate = 1'b1;
        tick();
        total++; if (cnt !== 16'd3) $display("[TB] FAIL gate_resume got %0d want 3", cnt); else passed++;
        urs = 1'b1; sm_reset = 1'b1;
        tick();
        total++; if ({cnt, uev, uif} !== {16'd0, 1'b1, 1'b0})
            $display("[TB] FAIL smrst got cnt=%0d uev=%b uif=%b want 0 1 0", cnt, uev, uif); else passed++;
        tick();
        total++; if ({cnt, uev} !== {16'd1, 1'b0})
            $display("[TB] FAIL smrst_level got cnt=%0d uev=%b want 1 0", cnt, uev); else passed++;
    endtask

    task automatic test_ug_priority();
        applyStimulus();
        arr = 16'd9; cen = 1'b1;
        tick();
        tick();
        tick();
        tick();
        dir = 1'b1;
        #1;
        total++; if (cnt !== 16'd3) $display("[TB] FAIL dir_nochange got %0d want 3", cnt); else passed++;
        tick();
        total++; if (cnt !== 16'd2) $display("[TB] FAIL dir_down got %0d want 2", cnt); else passed++;
        dir = 1'b0;
        tick();
        udis = 1'b1; ug = 1'b1;
        tick();
        ug = 1'b0;
        total++; if ({cnt, uev, uif} !== {16'd0, 1'b1, 1'b1})
            $display("[TB] FAIL ug_prio got cnt=%0d uev=%b uif=%b want 0 1 1", cnt, uev, uif); else passed++;
        arr = 16'd2;
        tick();
        uif_clr = 1'b1;
        tick();
        uif_clr = 1'b0;
        tick();
        total++; if ({cnt, uev, uif} !== {16'd0, 1'b0, 1'b0})
            $display("[TB] FAIL udis_wrap got cnt=%0d uev=%b uif=%b want 0 0 0", cnt, uev, uif); else passed++;
    endtask

    task automatic test_reset_midcount();
        applyStimulus();
        arr = 16'd9; cen = 1'b1;
        tick();
        tick();
        tick();
        rst = 1'b1; ug = 1'b1;
        tick();
        rst = 1'b0; ug = 1'b0;
        total++; if ({cnt, uev, uif, cnt_en} !== {16'd0, 3'b000})
            $display("[TB] FAIL rst_mid got cnt=%0d uev=%b uif=%b en=%b want 0 0 0 0", cnt, uev, uif, cnt_en); else passed++;
    endtask

    initial begin
        test_reset();
        test_up_count();
        test_down_prescale();
        test_arpe();
        test_one_pulse();
        test_gated_smreset();
        test_ug_priority();
        test_reset_midcount();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
